load_store_unit: RTL and testbench

//  Sits between the core's memory stage and the data RAM, and drives the RAM's MemWrite/MemRead/MemSize/A_Ram/WriteData pins.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a synchronous data RAM.
// Handles range/funct3 checks, byte-splitting of sub-word misaligned accesses and load extension.
module load_store_unit #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter logic [31:0] ADDR_LIMIT       = 32'h7D04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] asm_reg;
    logic [2:0]  nbytes_reg;
    logic        byte_mode_reg;
    logic [1:0]  beat_reg;
    logic        err_reg;

    logic [2:0]  req_nbytes;
    logic        f3_bad;
    logic        range_bad;
    logic        misaligned;
    logic        req_err;
    logic        req_byte_mode;
    logic [32:0] req_last;
    logic        last_beat;
    logic [7:0]  wdata_lane [4];

    // Request decode, evaluated on the accept cycle only
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        f3_bad        = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        (req_we && req_funct3[2]);
        req_last      = {1'b0, req_addr} + {30'd0, req_nbytes} - 33'd1;
        range_bad     = req_last >= {1'b0, ADDR_LIMIT};
        misaligned    = (req_nbytes != 3'd1) && (req_addr[1:0] != 2'b00);
        req_err       = f3_bad || range_bad || (misaligned && !ALLOW_MISALIGNED);
        req_byte_mode = (req_nbytes == 3'd1) || misaligned;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lane[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Whole-word/half ops are always a single beat
    assign last_beat = byte_mode_reg ? ({1'b0, beat_reg} == nbytes_reg - 3'd1) : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            asm_reg       <= 32'd0;
            nbytes_reg    <= 3'd0;
            byte_mode_reg <= 1'b0;
            beat_reg      <= 2'd0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        we_reg        <= req_we;
                        funct3_reg    <= req_funct3;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        nbytes_reg    <= req_nbytes;
                        byte_mode_reg <= req_byte_mode;
                        beat_reg      <= 2'd0;
                        asm_reg       <= 32'd0;
                        err_reg       <= req_err;
                        state_reg     <= req_err ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!we_reg) begin
                        state_reg <= S_CAPT;
                    end else if (last_beat) begin
                        state_reg <= S_RESP;
                    end else begin
                        beat_reg <= beat_reg + 2'd1;
                    end
                end
                S_CAPT: begin
                    if (byte_mode_reg) begin
                        asm_reg[{beat_reg, 3'b000} +: 8] <= mem_rdata[7:0];
                    end else begin
                        asm_reg <= mem_rdata;
                    end
                    if (last_beat) begin
                        state_reg <= S_RESP;
                    end else begin
                        beat_reg  <= beat_reg + 2'd1;
                        state_reg <= S_ISSUE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == S_IDLE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_err   = rsp_valid && err_reg;

    always_comb begin
        rsp_rdata = 32'd0;
        if (rsp_valid && !we_reg && !err_reg) begin
            case (funct3_reg)
                3'b000:  rsp_rdata = {{24{asm_reg[7]}}, asm_reg[7:0]};
                3'b001:  rsp_rdata = {{16{asm_reg[15]}}, asm_reg[15:0]};
                3'b100:  rsp_rdata = {24'd0, asm_reg[7:0]};
                3'b101:  rsp_rdata = {16'd0, asm_reg[15:0]};
                default: rsp_rdata = asm_reg;
            endcase
        end
    end

    // RAM pins are only non-zero while a beat is being issued
    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_size  = 3'b000;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state_reg == S_ISSUE) begin
            mem_write = we_reg;
            mem_read  = !we_reg;
            mem_size  = byte_mode_reg ? 3'b000 : {1'b0, funct3_reg[1:0]};
            mem_addr  = addr_reg + (byte_mode_reg ? {30'd0, beat_reg} : 32'd0);
            if (we_reg) begin
                mem_wdata = byte_mode_reg ? {24'd0, wdata_lane[beat_reg]} : wdata_reg;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM, transaction-level reference model with a
// per-cycle compare process, directed literal checks, reset abort and random mix.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err, mem_write, mem_read;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata = 32'd0;

    // second instance with misaligned splitting disabled
    logic        s_req_valid = 1'b0, s_req_we = 1'b0;
    logic [2:0]  s_req_funct3 = 3'd0;
    logic [31:0] s_req_addr = 32'd0, s_req_wdata = 32'd0;
    logic        s_req_ready, s_rsp_valid, s_rsp_err, s_mem_write, s_mem_read;
    logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
    logic [2:0]  s_mem_size;
    logic [31:0] s_mem_rdata;
    logic        s_wr_seen = 1'b0;
    assign s_mem_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
        .mem_write(s_mem_write), .mem_read(s_mem_read), .mem_size(s_mem_size),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
    );

    always @(posedge clk) if (s_mem_write) s_wr_seen <= 1'b1;

    // Synchronous RAM: byte/half/word writes, 1-cycle read latency, junk when not reading
    bit [7:0] ram [0:32767];

    function automatic logic [31:0] ram_rd(input logic [31:0] a, input logic [2:0] sz);
        logic [14:0] i;
        i = a[14:0];
        if (sz == 3'b000) return {24'd0, ram[i]};
        if (sz == 3'b001) return {16'd0, ram[i+15'd1], ram[i]};
        return {ram[i+15'd3], ram[i+15'd2], ram[i+15'd1], ram[i]};
    endfunction

    always @(posedge clk) begin
        if (!reset && mem_write && mem_addr < 32'd32768) begin
            ram[mem_addr[14:0]] <= mem_wdata[7:0];
            if (mem_size != 3'b000) ram[mem_addr[14:0]+15'd1] <= mem_wdata[15:8];
            if (mem_size == 3'b010) begin
                ram[mem_addr[14:0]+15'd2] <= mem_wdata[23:16];
                ram[mem_addr[14:0]+15'd3] <= mem_wdata[31:24];
            end
        end
        if (!reset && mem_read && mem_addr < 32'd32768) mem_rdata <= ram_rd(mem_addr, mem_size);
        else mem_rdata <= 32'hDEADBEEF;
    end

    // Reference model state
    bit [7:0]    model_mem [0:32767];
    bit          busy, m_we, m_err, m_bm, last_err;
    logic [2:0]  m_f3, m_size;
    logic [31:0] m_addr, m_wdata, m_rdata, last_rdata;
    int          d, lat_l, nbeats, acc_count, cyc, acc_cyc, rsp_cyc, rd_cnt, wr_cnt;
    int          errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
        int nb;
        longint last;
        logic [31:0] v;
        nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        last = longint'(a) + nb - 1;
        m_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
                (last >= 64'h7D04);
        m_we = we; m_f3 = f3; m_addr = a; m_wdata = wd;
        m_bm   = (nb == 1) || (a[1:0] != 2'b00);
        nbeats = m_bm ? nb : 1;
        m_size = m_bm ? 3'd0 : ((nb == 2) ? 3'd1 : 3'd2);
        m_rdata = 32'd0;
        if (m_err) begin
            lat_l = 1;
        end else if (we) begin
            lat_l = nbeats + 1;
            for (int i = 0; i < nb; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            lat_l = 2 * nbeats + 1;
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | ({24'd0, model_mem[int'(a) + i]} << (8 * i));
            if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            m_rdata = v;
        end
        busy = 1'b1; d = 0; acc_count++; acc_cyc = cyc; rd_cnt = 0; wr_cnt = 0;
    endtask

    // Compare process: every cycle, DUT pins against the model's expectation
    initial begin
        bit was, iss;
        int beat;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (reset) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_mem_write", mem_write, 0);
                chk("rst_mem_read", mem_read, 0);
                chk("rst_mem_size", mem_size, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                busy = 1'b0;
            end else begin
                was = busy;
                if (was) d++;
                iss = 1'b0; beat = 0;
                if (was && !m_err) begin
                    if (m_we && d <= nbeats) begin iss = 1'b1; beat = d - 1; end
                    if (!m_we && (d % 2) == 1 && d < lat_l) begin iss = 1'b1; beat = (d - 1) / 2; end
                end
                chk("req_ready", req_ready, !was);
                chk("mem_write", mem_write, iss && m_we);
                chk("mem_read", mem_read, iss && !m_we);
                if (iss) begin
                    chk("mem_size", mem_size, m_size);
                    chk("mem_addr", mem_addr, m_bm ? m_addr + beat : m_addr);
                    if (m_we) chk("mem_wdata", mem_wdata, m_bm ? {24'd0, m_wdata[8*beat +: 8]} : m_wdata);
                end else begin
                    chk("idle_mem_addr", mem_addr, 0);
                    chk("idle_mem_wdata", mem_wdata, 0);
                    chk("idle_mem_size", mem_size, 0);
                end
                chk("rsp_valid", rsp_valid, was && d == lat_l);
                if (was && d == lat_l) begin
                    chk("rsp_err", rsp_err, m_err);
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    last_rdata = rsp_rdata; last_err = rsp_err; rsp_cyc = cyc; busy = 1'b0;
                    $display("txn %0d we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                             acc_count, m_we, m_f3, m_addr, m_wdata, rsp_rdata, rsp_err, cyc - acc_cyc);
                end
                if (!was && req_valid) model_accept(req_we, req_funct3, req_addr, req_wdata);
            end
        end
    end

    // Called just after a posedge; presents the request until the model sees it accepted
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
        int n0, k;
        n0 = acc_count;
        #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        k = 0;
        do begin @(posedge clk); k++; end while (acc_count == n0 && k < 30);
        if (acc_count == n0) chk("accept_timeout", 0, 1);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        do begin @(posedge clk); k++; end while (busy && k < 60);
        if (busy) chk("rsp_timeout", 0, 1);
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        send(we, f3, a, wd);
        wait_done();
    endtask

    initial begin
        logic [2:0] legal [5];
        logic [31:0] a;
        logic [2:0] f3;
        int r;
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);

        // Aligned store then load
        do_txn(1'b1, 3'b010, 32'h100, 32'h8899AABB);
        chk("sw_aligned_lat", rsp_cyc - acc_cyc, 2);
        do_txn(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_data", last_rdata, 32'h8899AABB);
        chk("lw_err", last_err, 0);
        chk("lw_lat", rsp_cyc - acc_cyc, 3);
        chk("lw_reads", rd_cnt, 1);

        // Byte and split-half loads with extension
        do_txn(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_data", last_rdata, 32'hFFFFFF88);
        do_txn(1'b0, 3'b100, 32'h103, 32'h0);
        chk("lbu_data", last_rdata, 32'h00000088);
        do_txn(1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh_split_data", last_rdata, 32'hFFFF8899);
        chk("lh_split_reads", rd_cnt, 2);
        chk("lh_split_lat", rsp_cyc - acc_cyc, 5);

        // Misaligned word store split into four byte writes
        do_txn(1'b1, 3'b010, 32'h201, 32'h11223344);
        chk("sw_split_lat", rsp_cyc - acc_cyc, 5);
        chk("sw_split_writes", wr_cnt, 4);
        chk("sw_split_ram", {ram[15'h204], ram[15'h203], ram[15'h202], ram[15'h201]}, 32'h11223344);
        do_txn(1'b0, 3'b010, 32'h201, 32'h0);
        chk("lw_split_data", last_rdata, 32'h11223344);
        chk("lw_split_lat", rsp_cyc - acc_cyc, 9);

        // Errors and range boundary
        do_txn(1'b0, 3'b010, 32'h7D01, 32'h0);
        chk("range_err", last_err, 1);
        chk("range_rdata", last_rdata, 0);
        chk("range_lat", rsp_cyc - acc_cyc, 1);
        chk("range_reads", rd_cnt, 0);
        do_txn(1'b0, 3'b011, 32'h10, 32'h0);
        chk("f3_err", last_err, 1);
        chk("f3_reads", rd_cnt, 0);
        do_txn(1'b0, 3'b010, 32'h7D00, 32'h0);
        chk("range_edge_ok", last_err, 0);
        do_txn(1'b0, 3'b000, 32'h7D04, 32'h0);
        chk("range_edge_err", last_err, 1);
        do_txn(1'b1, 3'b100, 32'h40, 32'h1);
        chk("store_u_err", last_err, 1);

        // Strict instance: misaligned SH rejected without touching memory
        #1;
        s_req_valid = 1'b1; s_req_we = 1'b1; s_req_funct3 = 3'b001; s_req_addr = 32'h3;
        s_req_wdata = 32'hCAFE;
        @(negedge clk); chk("s_ready", s_req_ready, 1);
        @(posedge clk); #1 s_req_valid = 1'b0;
        @(negedge clk);
        chk("s_mis_valid", s_rsp_valid, 1);
        chk("s_mis_err", s_rsp_err, 1);
        chk("s_mis_rdata", s_rsp_rdata, 0);
        @(negedge clk); chk("s_mis_pulse", s_rsp_valid, 0);
        @(posedge clk); #1;
        s_req_valid = 1'b1; s_req_we = 1'b0; s_req_funct3 = 3'b010; s_req_addr = 32'h4;
        @(posedge clk); #1 s_req_valid = 1'b0;
        @(negedge clk);
        chk("s_lw_read", s_mem_read, 1);
        chk("s_lw_addr", s_mem_addr, 32'h4);
        @(negedge clk); chk("s_lw_capt", s_mem_read, 0);
        @(negedge clk);
        chk("s_lw_valid", s_rsp_valid, 1);
        chk("s_lw_err", s_rsp_err, 0);

        // Reset during CAPT of beat 1 of a split LW
        @(posedge clk);
        send(1'b0, 3'b010, 32'h301, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        @(posedge clk);
        do_txn(1'b1, 3'b000, 32'h305, 32'h5A5A5AA5);
        chk("post_rst_sb_err", last_err, 0);
        chk("post_rst_sb_lat", rsp_cyc - acc_cyc, 2);
        chk("post_rst_sb_writes", wr_cnt, 1);
        chk("post_rst_sb_ram", {24'd0, ram[15'h305]}, 32'hA5);

        // Random mix
        for (int n = 0; n < 300; n++) begin
            r = $urandom % 16;
            f3 = (r < 13) ? legal[r % 5] : 3'($urandom % 8);
            case ($urandom % 8)
                0:       a = 32'h7CF8 + ($urandom % 16);
                1:       a = $urandom;
                default: a = 32'h400 + ($urandom % 64);
            endcase
            repeat ($urandom % 3) @(posedge clk);
            do_txn(1'($urandom % 2), f3, a, $urandom);
        end

        repeat (2) @(posedge clk);
        chk("strict_no_write", s_wr_seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
